and_1: RTL and testbench
========================

// Module: and_1
// PURPOSE
//   Two-input bitwise AND gate with a zero-latency combinational output c = a & b.
//   Also provides a registered copy of the result and per-bit rising-edge pulses.
//   Leaf primitive for logic-gate labs and for glue logic in larger datapaths.
//   Output c never depends on clk or rst, so it works in clockless benches.
// PARAMETERS
//   WIDTH   1   bit width of a, b, c, c_q, c_rise; legal range 1..64
//   CNT_W   16  width of hit_cnt; legal range 1..32; used only when AND_STATS_EN is defined
// PORTS
//   clk      in   1      rising-edge clock for all registered outputs
//   rst      in   1      synchronous reset, active-high
//   c        out  WIDTH  combinational a & b
//   a        in   WIDTH  operand A
//   b        in   WIDTH  operand B
//   c_q      out  WIDTH  registered a & b
//   c_rise   out  WIDTH  one-cycle pulse per bit when that bit of c_q goes 0->1
//   hit_cnt  out  CNT_W  saturating count of cycles with |(a & b); present only with AND_STATS_EN
//   Positional declaration order is fixed: c, a, b, clk, rst, c_q, c_rise[, hit_cnt].
//   Positional instance and1(c,a,b) must elaborate; the unconnected inputs are then legal.
// BEHAVIOUR
//   - c = a & b, purely continuous: no clock, no latch, zero delta latency.
//     c follows every input change immediately.
//     Truth table per bit: 00->0, 01->0, 10->0, 11->1.
//   - X/Z handling follows Verilog '&': 0 & x = 0; 1 & x = x.
//   - Reset (rst=1 sampled on rising clk edge):
//     c_q <= 0, c_rise <= 0, hit_cnt <= 0. c is unaffected by reset.
//   - Normal edge (rst=0):
//     c_q <= a & b
//     c_rise <= (a & b) & ~c_q
//     So c_q has 1-cycle latency; c_rise is high for exactly one cycle.
//   - rst asserted mid-operation: all registered outputs clear on that edge.
//     The first edge after release reloads c_q from a & b. A 1 on that edge
//     counts as a rise, because c_q was 0 during reset.
//   - Inputs held constant: c_rise returns to 0 after one cycle.
//   - No state machine, no handshake; every input combination is legal.
// CONFIGURATION
//   AND_STATS_EN defined:
//     hit_cnt exists; it increments by 1 on each non-reset edge where |(a & b) is 1.
//     hit_cnt saturates at 2^CNT_W-1 and never wraps. It clears on rst.
//   AND_STATS_EN undefined:
//     hit_cnt port and counter logic are absent. All other behaviour is identical.
// TESTING
//   1. WIDTH=1, clk/rst undriven, a/b stepped every 1ns through 00,01,10,11.
//      -> c = 0,0,0,1 in the same timestep as each change.
//   2. rst=1 for 2 edges with a=b=1 -> c=1, c_q=0, c_rise=0.
//      Release rst -> next edge c_q=1, c_rise=1; the edge after that c_rise=0.
//   3. a=b=1 held, then b=0 -> c=0 immediately; c_q=0 after 1 edge; c_rise stays 0.
//   4. WIDTH=8, a=8'hF0, b=8'h3C -> c=8'h30.
//      After one edge c_q=8'h30 and c_rise=8'h30.
//   5. AND_STATS_EN, CNT_W=2, a=b=1 for 5 edges -> hit_cnt = 1,2,3,3,3.
//      Then rst -> hit_cnt=0.
//   6. Assert rst while c_q=1 -> c_q=0 on that edge, while c still equals a & b.

Source files
------------

// File: rtl/and_1.sv
// and_1: bitwise AND gate with a combinational output, a registered copy and
// per-bit rising-edge pulses on the registered copy.
// Optional feature macro: AND_STATS_EN adds hit_cnt, a saturating count of
// clock edges on which any bit of a & b is set.
// Port order is c, a, b, clk, rst, c_q, c_rise[, hit_cnt]. This keeps a
// three-port positional instance (c, a, b) legal for purely combinational use.
module and_1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    output logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] c_q,
    output logic [WIDTH-1:0] c_rise
`ifdef AND_STATS_EN
    ,
    output logic [CNT_W-1:0] hit_cnt
`endif
);

    // Elaboration-time range checks on the parameters.
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("and_1: WIDTH must be in 1..64");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("and_1: CNT_W must be in 1..32");
    end

    logic [WIDTH-1:0] c_q_d;
    logic [WIDTH-1:0] c_rise_d;
    logic [WIDTH-1:0] c_rise_q;

    // Combinational AND. It is independent of clk and rst, and X/Z propagates as in '&'.
    assign c = a & b;

    // Next state for the registered copy and the rise pulse.
    always_comb begin
        c_q_d    = a & b;
        c_rise_d = (a & b) & ~c_q;
    end

    // Registered copy and rise pulse. The synchronous reset clears both.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q      <= '0;
            c_rise_q <= '0;
        end else begin
            c_q      <= c_q_d;
            c_rise_q <= c_rise_d;
        end
    end

    assign c_rise = c_rise_q;

`ifdef AND_STATS_EN
    logic [CNT_W-1:0] hit_cnt_d;
    logic [CNT_W-1:0] hit_cnt_q;

    // Count edges with any active AND bit. The count holds once it reaches all-ones.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if ((|(a & b)) && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
    end

    // Hit counter register, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_and_1.sv
// Testbench for and_1. It drives two instances (WIDTH=1 and WIDTH=8) from
// directed and random stimulus and compares them with a behavioural model.
// With AND_STATS_EN defined, it also checks the saturating hit counters.
`timescale 1ns/1ps
module tb_and_1;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       c1, cq1, cr1;
    logic [7:0] c8, cq8, cr8;
`ifdef AND_STATS_EN
    logic [1:0] hc1;
    logic [2:0] hc8;
`endif

    int checks = 0;
    int failures = 0;

    // The model tracks the value last captured into each register.
    logic       m_cq1 = 1'b0, m_cr1 = 1'b0;
    logic [7:0] m_cq8 = '0, m_cr8 = '0;
    int         m_cnt1 = 0, m_cnt8 = 0;

    always #5 if (clk_en) clk = ~clk;

    and_1 #(.WIDTH(1), .CNT_W(2)) u_d1 (
        .c(c1), .a(a1), .b(b1), .clk(clk), .rst(rst), .c_q(cq1), .c_rise(cr1)
`ifdef AND_STATS_EN
        , .hit_cnt(hc1)
`endif
    );

    and_1 #(.WIDTH(8), .CNT_W(3)) u_d8 (
        .c(c8), .a(a8), .b(b8), .clk(clk), .rst(rst), .c_q(cq8), .c_rise(cr8)
`ifdef AND_STATS_EN
        , .hit_cnt(hc8)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one input set at the negedge, check c combinationally, clock once,
    // then check the registered outputs against the model.
    task automatic step(input logic [7:0] av, input logic [7:0] bv,
                        input logic a1v, input logic b1v, input logic rv);
        @(negedge clk);
        a8 = av; b8 = bv; a1 = a1v; b1 = b1v; rst = rv;
        #1;
        chk("c8", 64'(c8), 64'(av & bv));
        chk("c1", 64'(c1), 64'(a1v & b1v));
        @(posedge clk);
        if (rv) begin
            m_cq8 = '0; m_cr8 = '0; m_cq1 = 1'b0; m_cr1 = 1'b0;
            m_cnt1 = 0; m_cnt8 = 0;
        end else begin
            // A rise is a bit that is 1 now and was 0 in the previous captured value.
            m_cr8 = (av & bv) & ~m_cq8;
            m_cq8 = av & bv;
            m_cr1 = (a1v & b1v) & ~m_cq1;
            m_cq1 = a1v & b1v;
            if ((av & bv) != 0 && m_cnt8 < 7) m_cnt8++;
            if ((a1v & b1v) && m_cnt1 < 3) m_cnt1++;
        end
        #1;
        chk("c_q8", 64'(cq8), 64'(m_cq8));
        chk("c_rise8", 64'(cr8), 64'(m_cr8));
        chk("c_q1", 64'(cq1), 64'(m_cq1));
        chk("c_rise1", 64'(cr1), 64'(m_cr1));
`ifdef AND_STATS_EN
        chk("hit_cnt8", 64'(hc8), 64'(m_cnt8));
        chk("hit_cnt1", 64'(hc1), 64'(m_cnt1));
`endif
    endtask

    initial begin
        logic [1:0] tt_a, tt_b;
        logic [3:0] tt_c;
        tt_a = 2'b01;
        tt_b = 2'b10;
        tt_c = 4'b1000;

        // Truth table with the clock idle. c must follow each change within the same ns.
        for (int i = 0; i < 4; i++) begin
            a1 = tt_b[i[1:0] >> 1];
            b1 = tt_a[i[1:0] & 2'b01];
            a1 = i[1];
            b1 = i[0];
            #0.1;
            chk("truth_table", 64'(c1), 64'(tt_c[i]));
            #0.9;
        end

        clk_en = 1'b1;

        // Reset for two edges with a=b=1: c stays 1, and the registered outputs are 0.
        step(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
        step(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
        chk("rst_c_q_zero", 64'(cq1), 64'(0));
        // Release reset: the first edge gives a rise, and the next edge clears it.
        step(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
        chk("rel_rise", 64'(cr1), 64'(1));
        step(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
        chk("rise_one_cycle", 64'(cr1), 64'(0));
        // Continue holding a=b=1 so the 2-bit counter saturates.
        step(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
        step(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
        step(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
        // b goes to 0: c falls at once, c_q falls on the next edge, and no rise is seen.
        step(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        // Multi-bit case F0 & 3C = 30, with a rise on the same bits.
        step(8'hF0, 8'h3C, 1'b1, 1'b1, 1'b0);
        chk("c_q8_30", 64'(cq8), 64'h30);
        chk("c_rise8_30", 64'(cr8), 64'h30);
        // Assert reset while c_q is 1: the registers clear, and c still follows a & b.
        step(8'hF0, 8'h3C, 1'b1, 1'b1, 1'b1);
        step(8'hF0, 8'h3C, 1'b1, 1'b1, 1'b0);

        // Random stimulus with occasional resets.
        for (int n = 0; n < 300; n++) begin
            step(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 19) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
